axil_read_arbiter: RTL and testbench

- Shares one downstream AXI-Lite read port (to a single AXI-Lite read slave) among NUM_MASTERS upstream AXI-Lite read masters.
- Round-robin arbitration, one outstanding transaction at a time.
- Per-transaction timeout returns SLVERR so a dead slave cannot hang the fabric.
- Sits between the interconnect's master-side read ports and a peripheral's AXI-Lite slave read interface.

---
 rtl/axil_read_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_axil_read_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_read_arbiter.sv
// Round-robin arbiter that shares one AXI-Lite read slave port among several read masters.
// Only one transaction is in flight at a time; a per-transaction timeout answers SLVERR when the slave stalls.
module axil_read_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                          S_AXIL_ACLK,
    input  logic                          S_AXIL_ARESET,
    input  logic [NUM_MASTERS-1:0]        S_AXIL_ARVALID,
    output logic [NUM_MASTERS-1:0]        S_AXIL_ARREADY,
    input  logic [NUM_MASTERS*ADDR_W-1:0] S_AXIL_ARADDR,
    input  logic [NUM_MASTERS*3-1:0]      S_AXIL_ARPROT,
    output logic [NUM_MASTERS-1:0]        S_AXIL_RVALID,
    input  logic [NUM_MASTERS-1:0]        S_AXIL_RREADY,
    output logic [DATA_W-1:0]             S_AXIL_RDATA,
    output logic [1:0]                    S_AXIL_RRESP,
    output logic                          M_AXIL_ARVALID,
    input  logic                          M_AXIL_ARREADY,
    output logic [ADDR_W-1:0]             M_AXIL_ARADDR,
    output logic [2:0]                    M_AXIL_ARPROT,
    input  logic                          M_AXIL_RVALID,
    output logic                          M_AXIL_RREADY,
    input  logic [DATA_W-1:0]             M_AXIL_RDATA,
    input  logic [1:0]                    M_AXIL_RRESP
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [GW:0] NUM_W = (GW + 1)'(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DATA  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [GW-1:0]       grant_r, grant_s;
    logic [GW-1:0]       rr_ptr_r, rr_ptr_s;
    logic                stale_r, stale_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [DATA_W-1:0]   rdata_s;
    logic [1:0]          rresp_s;
    logic [ADDR_W-1:0]   araddr_s;
    logic [2:0]          arprot_s;
    logic                pick_found_s;
    logic [GW-1:0]       pick_idx_s;
    logic [GW:0]         cand_s;
    logic                ar_hs_s, m_ar_hs_s, m_r_hs_s, s_r_hs_s, tmo_s;
    logic [NUM_MASTERS-1:0] grant_oh_s;

    assign ar_hs_s   = S_AXIL_ARVALID[grant_r] & S_AXIL_ARREADY[grant_r];
    assign m_ar_hs_s = M_AXIL_ARVALID & M_AXIL_ARREADY;
    assign m_r_hs_s  = M_AXIL_RVALID & M_AXIL_RREADY;
    assign s_r_hs_s  = S_AXIL_RVALID[grant_r] & S_AXIL_RREADY[grant_r];
    assign tmo_s     = (TIMEOUT > 0) && (cnt_r == CNT_LAST);
    assign grant_oh_s = ONE_HOT0 << grant_s;

    // Round-robin search: first requester strictly after rr_ptr, wrapping around
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand_s = {1'b0, rr_ptr_r} + (GW + 1)'(i);
            if (cand_s >= NUM_W) begin
                cand_s = cand_s - NUM_W;
            end else begin
                cand_s = cand_s;
            end
            if (!pick_found_s && S_AXIL_ARVALID[cand_s[GW-1:0]]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s[GW-1:0];
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_s  = state_r;
        grant_s  = grant_r;
        rr_ptr_s = rr_ptr_r;
        stale_s  = stale_r;
        cnt_s    = cnt_r;
        rdata_s  = S_AXIL_RDATA;
        rresp_s  = S_AXIL_RRESP;
        araddr_s = M_AXIL_ARADDR;
        arprot_s = M_AXIL_ARPROT;

        // A late response from a timed-out transaction is swallowed here
        if (stale_r && m_r_hs_s) begin
            stale_s = 1'b0;
        end else begin
            stale_s = stale_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (!stale_r && pick_found_s) begin
                    grant_s  = pick_idx_s;
                    rr_ptr_s = pick_idx_s;
                    state_s  = ST_GRANT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (ar_hs_s) begin
                    araddr_s = S_AXIL_ARADDR[grant_r*ADDR_W +: ADDR_W];
                    arprot_s = S_AXIL_ARPROT[grant_r*3 +: 3];
                    cnt_s    = '0;
                    state_s  = ST_ADDR;
                end else begin
                    state_s = ST_GRANT;
                end
            end
            ST_ADDR: begin
                // Address accepted on the timeout cycle still leaves a response owed
                if (tmo_s) begin
                    rdata_s = '0;
                    rresp_s = RESP_SLVERR;
                    stale_s = m_ar_hs_s;
                    state_s = ST_RESP;
                end else if (m_ar_hs_s) begin
                    cnt_s   = cnt_r + CW'(1);
                    state_s = ST_DATA;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                    state_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (m_r_hs_s) begin
                    rdata_s = M_AXIL_RDATA;
                    rresp_s = M_AXIL_RRESP;
                    state_s = ST_RESP;
                end else if (tmo_s) begin
                    rdata_s = '0;
                    rresp_s = RESP_SLVERR;
                    stale_s = 1'b1;
                    state_s = ST_RESP;
                end else begin
                    cnt_s   = cnt_r + CW'(1);
                    state_s = ST_DATA;
                end
            end
            ST_RESP: begin
                if (s_r_hs_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state
    always_ff @(posedge S_AXIL_ACLK) begin
        if (S_AXIL_ARESET) begin
            state_r        <= ST_IDLE;
            grant_r        <= '0;
            rr_ptr_r       <= GW'(NUM_MASTERS - 1);
            stale_r        <= 1'b0;
            cnt_r          <= '0;
            S_AXIL_ARREADY <= '0;
            S_AXIL_RVALID  <= '0;
            S_AXIL_RDATA   <= '0;
            S_AXIL_RRESP   <= 2'b00;
            M_AXIL_ARVALID <= 1'b0;
            M_AXIL_ARADDR  <= '0;
            M_AXIL_ARPROT  <= 3'b000;
            M_AXIL_RREADY  <= 1'b0;
        end else begin
            state_r        <= state_s;
            grant_r        <= grant_s;
            rr_ptr_r       <= rr_ptr_s;
            stale_r        <= stale_s;
            cnt_r          <= cnt_s;
            S_AXIL_ARREADY <= (state_s == ST_GRANT) ? grant_oh_s : '0;
            S_AXIL_RVALID  <= (state_s == ST_RESP) ? grant_oh_s : '0;
            S_AXIL_RDATA   <= rdata_s;
            S_AXIL_RRESP   <= rresp_s;
            M_AXIL_ARVALID <= (state_s == ST_ADDR);
            M_AXIL_ARADDR  <= araddr_s;
            M_AXIL_ARPROT  <= arprot_s;
            M_AXIL_RREADY  <= (state_s == ST_DATA) || stale_s;
        end
    end

endmodule

// File: tb/tb_axil_read_arbiter.sv
// Directed bench for axil_read_arbiter: instance a uses the default timeout, instance b uses TIMEOUT=8.
module tb_axil_read_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [N-1:0]    a_arvalid, a_arready, a_rvalid, a_rready;
    logic [N*32-1:0] a_araddr;
    logic [N*3-1:0]  a_arprot;
    logic [31:0]     a_rdata, a_maraddr, a_mrdata;
    logic [1:0]      a_rresp, a_mrresp;
    logic            a_marvalid, a_marready, a_mrvalid, a_mrready;
    logic [2:0]      a_marprot;

    logic [N-1:0]    b_arvalid, b_arready, b_rvalid, b_rready;
    logic [N*32-1:0] b_araddr;
    logic [N*3-1:0]  b_arprot;
    logic [31:0]     b_rdata, b_maraddr, b_mrdata;
    logic [1:0]      b_rresp, b_mrresp;
    logic            b_marvalid, b_marready, b_mrvalid, b_mrready;
    logic [2:0]      b_marprot;

    axil_read_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut_a (
        .S_AXIL_ACLK(clk), .S_AXIL_ARESET(rst),
        .S_AXIL_ARVALID(a_arvalid), .S_AXIL_ARREADY(a_arready),
        .S_AXIL_ARADDR(a_araddr), .S_AXIL_ARPROT(a_arprot),
        .S_AXIL_RVALID(a_rvalid), .S_AXIL_RREADY(a_rready),
        .S_AXIL_RDATA(a_rdata), .S_AXIL_RRESP(a_rresp),
        .M_AXIL_ARVALID(a_marvalid), .M_AXIL_ARREADY(a_marready),
        .M_AXIL_ARADDR(a_maraddr), .M_AXIL_ARPROT(a_marprot),
        .M_AXIL_RVALID(a_mrvalid), .M_AXIL_RREADY(a_mrready),
        .M_AXIL_RDATA(a_mrdata), .M_AXIL_RRESP(a_mrresp)
    );

    axil_read_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut_b (
        .S_AXIL_ACLK(clk), .S_AXIL_ARESET(rst),
        .S_AXIL_ARVALID(b_arvalid), .S_AXIL_ARREADY(b_arready),
        .S_AXIL_ARADDR(b_araddr), .S_AXIL_ARPROT(b_arprot),
        .S_AXIL_RVALID(b_rvalid), .S_AXIL_RREADY(b_rready),
        .S_AXIL_RDATA(b_rdata), .S_AXIL_RRESP(b_rresp),
        .M_AXIL_ARVALID(b_marvalid), .M_AXIL_ARREADY(b_marready),
        .M_AXIL_ARADDR(b_maraddr), .M_AXIL_ARPROT(b_marprot),
        .M_AXIL_RVALID(b_mrvalid), .M_AXIL_RREADY(b_mrready),
        .M_AXIL_RDATA(b_mrdata), .M_AXIL_RRESP(b_mrresp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lat, xfers, bad, leaked, exp_m;
    logic [N-1:0] others;

    initial begin
        a_arvalid = '0; a_rready = 4'hF; a_araddr = '0; a_arprot = '0;
        a_marready = 1'b1; a_mrvalid = 1'b1; a_mrdata = 32'hDEAD_BEEF; a_mrresp = 2'b00;
        b_arvalid = '0; b_rready = 4'hF; b_araddr = '0; b_arprot = '0;
        b_marready = 1'b1; b_mrvalid = 1'b0; b_mrdata = 32'h0; b_mrresp = 2'b00;
        rst = 1'b1;
        tick(); tick();
        check("reset_ctrl", {a_arready, a_rvalid, a_marvalid, a_mrready, a_rresp}, 64'h0);
        check("reset_data", {a_rdata, a_maraddr}, 64'h0);
        rst = 1'b0;
        tick();

        // single request from master 2, zero-wait slave
        a_araddr[2*32 +: 32] = 32'h0000_0010;
        a_arvalid = 4'b0100;
        lat = 0;
        others = '0;
        for (int k = 1; k <= 10 && a_rvalid == '0; k++) begin
            tick();
            lat = k;
            if (k == 1) check("single_arready", a_arready, 64'h4);
            if (k == 2) check("single_maraddr", a_maraddr, 64'h10);
            if (a_marvalid) a_arvalid = '0;
            others = others | ((a_arready | a_rvalid) & 4'b1011);
        end
        check("single_latency", lat, 64'd4);
        check("single_rvalid", a_rvalid, 64'h4);
        check("single_rdata", a_rdata, 64'hDEAD_BEEF);
        check("single_rresp", a_rresp, 64'h0);
        tick();
        check("single_others", others, 64'h0);
        check("single_rvalid_drop", a_rvalid, 64'h0);

        // fairness after a fresh reset: all masters request continuously
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < N; i++) a_araddr[i*32 +: 32] = 32'h1000 + 32'(i) * 32'h100;
        a_arvalid = 4'hF;
        for (int t = 0; t < 8; t++) begin
            exp_m = t % 4;
            for (int k = 0; k < 10 && a_arready == '0; k++) tick();
            check("fair_grant", a_arready, 64'(1) << exp_m);
            tick();
            check("fair_addr", a_maraddr, 64'h1000 + 64'(exp_m) * 64'h100);
            for (int k = 0; k < 10 && a_rvalid == '0; k++) tick();
            check("fair_rvalid", a_rvalid, 64'(1) << exp_m);
            tick();
        end
        a_arvalid = '0;
        tick();

        // backpressure: master 1, slave ARREADY after 3 cycles, RVALID after 5, master RREADY low 2 cycles
        a_marready = 1'b0; a_mrvalid = 1'b0;
        a_rready = 4'b1101;
        a_araddr[1*32 +: 32] = 32'h0000_0020;
        a_arprot[1*3 +: 3] = 3'b101;
        a_arvalid = 4'b0010;
        for (int k = 0; k < 10 && !a_marvalid; k++) tick();
        a_arvalid = '0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            if (!a_marvalid || a_maraddr !== 32'h20 || a_marprot !== 3'b101) bad++;
            tick();
        end
        check("bp_ar_hold", bad, 64'd0);
        a_marready = 1'b1;
        tick();
        a_marready = 1'b0;
        check("bp_ar_done", {a_marvalid, a_mrready}, 64'b01);
        for (int k = 0; k < 5; k++) begin
            if (!a_mrready || a_rvalid != '0 || a_maraddr !== 32'h20) bad++;
            tick();
        end
        check("bp_data_wait", bad, 64'd0);
        a_mrvalid = 1'b1; a_mrdata = 32'hCAFE_F00D; a_mrresp = 2'b00;
        tick();
        a_mrvalid = 1'b0; a_mrdata = 32'h0;
        xfers = 0;
        lat = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) a_rready = 4'hF;
            if (a_rvalid != '0) begin
                lat++;
                if (a_rvalid !== 4'b0010 || a_rdata !== 32'hCAFE_F00D) bad++;
                if (a_rready[1]) xfers++;
            end
            tick();
        end
        check("bp_rdata_hold", bad, 64'd0);
        check("bp_rvalid_cycles", lat, 64'd3);
        check("bp_one_xfer", xfers, 64'd1);

        // SLVERR passthrough for master 3
        a_marready = 1'b1; a_mrvalid = 1'b1; a_mrdata = 32'h1234_5678; a_mrresp = 2'b10;
        a_araddr[3*32 +: 32] = 32'h0000_0030;
        a_arvalid = 4'b1000;
        for (int k = 0; k < 10 && a_rvalid == '0; k++) begin
            tick();
            if (a_marvalid) a_arvalid = '0;
        end
        check("slverr_rvalid", a_rvalid, 64'h8);
        check("slverr_rdata", a_rdata, 64'h1234_5678);
        check("slverr_rresp", a_rresp, 64'h2);
        tick();

        // reset while master 1 waits in DATA
        a_mrvalid = 1'b0;
        a_arvalid = 4'b0010;
        for (int k = 0; k < 10 && !a_mrready; k++) begin
            tick();
            if (a_marvalid) a_arvalid = '0;
        end
        check("rst_mid_in_data", a_mrready, 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_ctrl", {a_arready, a_rvalid, a_marvalid, a_mrready, a_rresp}, 64'h0);
        check("rst_mid_data", {a_rdata, a_maraddr}, 64'h0);
        a_mrvalid = 1'b1;
        a_arvalid = 4'hF;
        for (int k = 0; k < 10 && a_arready == '0; k++) tick();
        check("rst_mid_first_grant", a_arready, 64'h1);
        a_arvalid = '0;

        // timeout in DATA on instance b (TIMEOUT=8), slave never answers
        b_araddr[0 +: 32] = 32'h0000_0040;
        b_arvalid = 4'b0001;
        for (int k = 0; k < 10 && !b_marvalid; k++) tick();
        b_arvalid = '0;
        lat = 0;
        for (int k = 0; k < 20 && b_rvalid == '0; k++) begin
            tick();
            lat++;
        end
        check("tmo_latency", lat, 64'd8);
        check("tmo_rvalid", b_rvalid, 64'h1);
        check("tmo_rresp", b_rresp, 64'h2);
        check("tmo_rdata", b_rdata, 64'h0);
        b_arvalid = 4'b0010;
        tick();
        leaked = 0;
        for (int k = 0; k < 20; k++) begin
            if (b_arready != '0 || b_rvalid != '0 || !b_mrready) leaked++;
            tick();
        end
        check("tmo_stale_hold", leaked, 64'd0);
        b_mrvalid = 1'b1; b_mrdata = 32'h0000_0BAD; b_mrresp = 2'b00;
        tick();
        b_mrvalid = 1'b0;
        check("tmo_late_consumed", {b_arready, b_rvalid, b_mrready}, 64'h0);
        tick();
        check("tmo_next_grant", b_arready, 64'h2);

        // timeout in ADDR: slave never accepts the address
        b_marready = 1'b0;
        tick();
        check("tmo_addr_enter", b_marvalid, 64'h1);
        b_arvalid = '0;
        lat = 0;
        for (int k = 0; k < 20 && b_rvalid == '0; k++) begin
            tick();
            lat++;
        end
        check("tmo_addr_latency", lat, 64'd8);
        check("tmo_addr_arvalid_drop", b_marvalid, 64'h0);
        check("tmo_addr_rresp", {b_rvalid, b_rresp}, {58'h0, 4'b0010, 2'b10});
        tick();
        check("tmo_addr_no_stale", {b_mrready, b_rvalid}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
